// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: memop encoding, pipeline
// register layouts and small decode helpers.
package mem_access_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  // Memory operation codes; bit 3 marks a store.
  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LBU  = 4'd2,
    MEMOP_LH   = 4'd3,
    MEMOP_LHU  = 4'd4,
    MEMOP_LW   = 4'd5,
    MEMOP_SB   = 4'd9,
    MEMOP_SH   = 4'd10,
    MEMOP_SW   = 4'd11
  } memop_e;

  // Entry held in the MEM register.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] wdata;
    memop_e            memop;
    logic              regwrite;
    logic [REG_W-1:0]  writereg;
  } mem_entry_t;

  // Entry held in the WB register; the byte offset is aluout[1:0].
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] aluout;
    memop_e            memop;
    logic              regwrite;
    logic [REG_W-1:0]  writereg;
  } wb_entry_t;

  function automatic logic is_load(input memop_e op);
    return op inside {MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW};
  endfunction

  function automatic logic is_store(input memop_e op);
    return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW};
  endfunction

  // Halfword ops need addr[0]==0, word ops need addr[1:0]==0.
  function automatic logic misaligned(input memop_e op, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: bad = a[0];
      MEMOP_LW, MEMOP_SW:            bad = (a != 2'b00);
      default:                       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// mem_load_align: combinational load formatter. Picks the byte/half at the
// access offset and sign- or zero-extends it; LW passes the word through.
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  memop_e      op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension of the returned SRAM word.
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    result   = '0;
    case (op)
      MEMOP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_LBU: result = {24'd0, byte_sel};
      MEMOP_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEMOP_LHU: result = {16'd0, half_sel};
      MEMOP_LW:  result = rdata;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between EXE and WB. Registers the EXE
// entry into MEM, drives the data SRAM from MEM, registers MEM into WB and
// formats load data in WB.
// Optional feature: define ADDR_EXC_EN to enable alignment checking with
// exc_adel/exc_ades/exc_badvaddr reporting; otherwise exc_* are tied low.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush,
  input  logic              e_valid,
  input  logic [AW-1:0]     e_pc,
  input  logic [AW-1:0]     e_aluout,
  input  logic [AW-1:0]     e_wdata,
  input  logic [3:0]        e_memop,
  input  logic              e_regwrite,
  input  logic [REG_AW-1:0] e_writereg,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [AW-1:0]     data_sram_addr,
  output logic [AW-1:0]     data_sram_wdata,
  input  logic [AW-1:0]     data_sram_rdata,
  output logic              m_regwrite,
  output logic [REG_AW-1:0] m_writereg,
  output logic              w_valid,
  output logic [AW-1:0]     w_pc,
  output logic              w_regwrite,
  output logic [REG_AW-1:0] w_writereg,
  output logic [AW-1:0]     w_result,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [AW-1:0]     exc_badvaddr
);

  mem_entry_t  m_q;
  wb_entry_t   w_q;
  logic        m_load;
  logic        m_store;
  logic        addr_err;
  logic        access;
  logic [3:0]  store_mask;
  logic [31:0] store_data;
  logic [31:0] load_result;

  // MEM register: flush beats stall; invalid entries are stored as all-zero
  // so a bubble never exposes stale fields downstream.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      m_q <= '0;
    end else if (!stall) begin
      if (e_valid) begin
        m_q <= '{valid:    1'b1,
                 pc:       e_pc,
                 aluout:   e_aluout,
                 wdata:    e_wdata,
                 memop:    memop_e'(e_memop),
                 regwrite: e_regwrite,
                 writereg: e_writereg};
      end else begin
        m_q <= '0;
      end
    end
  end

  // Access qualification and address-error detection for the MEM entry.
  always_comb begin
    m_load  = is_load(m_q.memop);
    m_store = is_store(m_q.memop);
`ifdef ADDR_EXC_EN
    addr_err = m_q.valid & misaligned(m_q.memop, m_q.aluout[1:0]);
`else
    addr_err = 1'b0;
`endif
    access = m_q.valid & (m_q.memop != MEMOP_NONE) & ~stall & ~flush & ~addr_err;
  end

  // Store byte-lane enables and lane-replicated write data.
  always_comb begin
    store_mask = '0;
    store_data = m_q.wdata;
    case (m_q.memop)
      MEMOP_SB: begin
        store_mask = 4'b0001 << m_q.aluout[1:0];
        store_data = {4{m_q.wdata[7:0]}};
      end
      MEMOP_SH: begin
        store_mask = 4'b0011 << {m_q.aluout[1], 1'b0};
        store_data = {2{m_q.wdata[15:0]}};
      end
      MEMOP_SW: begin
        store_mask = '1;
        store_data = m_q.wdata;
      end
      default: begin
        store_mask = '0;
        store_data = m_q.wdata;
      end
    endcase
  end

  assign data_sram_en    = access;
  assign data_sram_wen   = (access & m_store) ? store_mask : '0;
  assign data_sram_addr  = m_q.aluout;
  assign data_sram_wdata = store_data;

  assign m_regwrite = m_q.valid & m_q.regwrite;
  assign m_writereg = m_q.writereg;

  // WB register: stall or flush inserts a bubble; an address error cancels
  // the GPR write but still retires the entry.
  always_ff @(posedge clk) begin
    if (!resetn || flush || stall) begin
      w_q <= '0;
    end else begin
      w_q <= '{valid:    m_q.valid,
               pc:       m_q.pc,
               aluout:   m_q.aluout,
               memop:    m_q.memop,
               regwrite: m_q.valid & m_q.regwrite & ~addr_err,
               writereg: m_q.writereg};
    end
  end

  mem_load_align u_load_align (
    .op     (w_q.memop),
    .offset (w_q.aluout[1:0]),
    .rdata  (data_sram_rdata),
    .result (load_result)
  );

  assign w_valid    = w_q.valid;
  assign w_pc       = w_q.pc;
  assign w_regwrite = w_q.regwrite;
  assign w_writereg = w_q.writereg;
  assign w_result   = is_load(w_q.memop) ? load_result : w_q.aluout;

`ifdef ADDR_EXC_EN
  assign exc_adel     = addr_err & m_load;
  assign exc_ades     = addr_err & m_store;
  assign exc_badvaddr = addr_err ? m_q.aluout : '0;
`else
  assign exc_adel     = 1'b0;
  assign exc_ades     = 1'b0;
  assign exc_badvaddr = '0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a small
// synchronous SRAM model (read data one cycle after the access).
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        flush;
  logic        e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_aluout;
  logic [31:0] e_wdata;
  logic [3:0]  e_memop;
  logic        e_regwrite;
  logic [4:0]  e_writereg;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        m_regwrite;
  logic [4:0]  m_writereg;
  logic        w_valid;
  logic [31:0] w_pc;
  logic        w_regwrite;
  logic [4:0]  w_writereg;
  logic [31:0] w_result;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned writes;

  logic [31:0] sram [0:255];

  always #5 clk = ~clk;

  mem_access_stage #(.AW(32), .REG_AW(5)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .flush           (flush),
    .e_valid         (e_valid),
    .e_pc            (e_pc),
    .e_aluout        (e_aluout),
    .e_wdata         (e_wdata),
    .e_memop         (e_memop),
    .e_regwrite      (e_regwrite),
    .e_writereg      (e_writereg),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .m_regwrite      (m_regwrite),
    .m_writereg      (m_writereg),
    .w_valid         (w_valid),
    .w_pc            (w_pc),
    .w_regwrite      (w_regwrite),
    .w_writereg      (w_writereg),
    .w_result        (w_result),
    .exc_adel        (exc_adel),
    .exc_ades        (exc_ades),
    .exc_badvaddr    (exc_badvaddr)
  );

  // Synchronous SRAM model with byte write enables.
  always @(posedge clk) begin
    if (data_sram_en) begin
      data_sram_rdata <= sram[data_sram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (data_sram_wen[b]) sram[data_sram_addr[9:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input memop_e op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rw, input logic [4:0] wr, input logic [31:0] pc);
    e_valid    = 1'b1;
    e_memop    = op;
    e_aluout   = addr;
    e_wdata    = wd;
    e_regwrite = rw;
    e_writereg = wr;
    e_pc       = pc;
    step();
  endtask

  task automatic set_idle();
    e_valid    = 1'b0;
    e_memop    = MEMOP_NONE;
    e_aluout   = '0;
    e_wdata    = '0;
    e_regwrite = 1'b0;
    e_writereg = '0;
    e_pc       = '0;
  endtask

  task automatic idle();
    set_idle();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = '0;
    data_sram_rdata = '0;
    resetn = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    set_idle();
    step();
    step();
    check("rst_en",      {31'd0, data_sram_en}, 32'd0);
    check("rst_wen",     {28'd0, data_sram_wen}, 32'd0);
    check("rst_w_valid", {31'd0, w_valid}, 32'd0);
    check("rst_w_result", w_result, 32'd0);
    check("rst_m_regwrite", {31'd0, m_regwrite}, 32'd0);
    check("rst_exc", {30'd0, exc_adel, exc_ades} | exc_badvaddr, 32'd0);
    resetn = 1'b1;
    idle();

    // Word store then word load
    issue(MEMOP_SW, 32'h100, 32'h12345678, 1'b0, 5'd0, 32'h1000);
    check("sw_en",    {31'd0, data_sram_en}, 32'd1);
    check("sw_wen",   {28'd0, data_sram_wen}, 32'hF);
    check("sw_addr",  data_sram_addr, 32'h100);
    check("sw_wdata", data_sram_wdata, 32'h12345678);
    issue(MEMOP_LW, 32'h100, 32'h0, 1'b1, 5'd5, 32'h1004);
    check("lw_en",  {31'd0, data_sram_en}, 32'd1);
    check("lw_wen", {28'd0, data_sram_wen}, 32'h0);
    check("lw_m_regwrite", {31'd0, m_regwrite}, 32'd1);
    check("lw_m_writereg", {27'd0, m_writereg}, 32'd5);
    check("sw_w_valid", {31'd0, w_valid}, 32'd1);
    check("sw_w_pc", w_pc, 32'h1000);
    check("sw_w_regwrite", {31'd0, w_regwrite}, 32'd0);
    idle();
    check("lw_w_pc", w_pc, 32'h1004);
    check("lw_w_regwrite", {31'd0, w_regwrite}, 32'd1);
    check("lw_w_writereg", {27'd0, w_writereg}, 32'd5);
    check("lw_result", w_result, 32'h12345678);

    // Byte store and signed/unsigned byte loads, back to back
    issue(MEMOP_SB, 32'h103, 32'h123456AB, 1'b0, 5'd0, 32'h1008);
    check("sb_wen",   {28'd0, data_sram_wen}, 32'h8);
    check("sb_wdata", data_sram_wdata, 32'hABABABAB);
    issue(MEMOP_LB,  32'h103, 32'h0, 1'b1, 5'd6, 32'h100C);
    issue(MEMOP_LBU, 32'h103, 32'h0, 1'b1, 5'd7, 32'h1010);
    check("lb_result", w_result, 32'hFFFFFFAB);
    idle();
    check("lbu_result", w_result, 32'h000000AB);

    // Halfword store into upper half, read back whole word
    issue(MEMOP_SH, 32'h102, 32'hFFFFBEEF, 1'b0, 5'd0, 32'h1014);
    check("sh_wen",   {28'd0, data_sram_wen}, 32'hC);
    check("sh_wdata", data_sram_wdata, 32'hBEEFBEEF);
    issue(MEMOP_LW, 32'h100, 32'h0, 1'b1, 5'd8, 32'h1018);
    idle();
    check("sh_readback", w_result, 32'hBEEF5678);

    // Halfword loads with sign bit set
    issue(MEMOP_SW,  32'h200, 32'h80001234, 1'b0, 5'd0, 32'h101C);
    issue(MEMOP_LH,  32'h202, 32'h0, 1'b1, 5'd9, 32'h1020);
    issue(MEMOP_LHU, 32'h202, 32'h0, 1'b1, 5'd9, 32'h1024);
    check("lh_result", w_result, 32'hFFFF8000);
    idle();
    check("lhu_result", w_result, 32'h00008000);

    // Non-memory op passes aluout
    issue(MEMOP_NONE, 32'hDEADBEEF, 32'h0, 1'b1, 5'd9, 32'h1028);
    check("alu_en", {31'd0, data_sram_en}, 32'd0);
    idle();
    check("alu_result", w_result, 32'hDEADBEEF);
    check("alu_w_regwrite", {31'd0, w_regwrite}, 32'd1);

`ifdef ADDR_EXC_EN
    issue(MEMOP_LW, 32'h101, 32'h0, 1'b1, 5'd10, 32'h102C);
    check("adel_flag", {31'd0, exc_adel}, 32'd1);
    check("adel_ades", {31'd0, exc_ades}, 32'd0);
    check("adel_badvaddr", exc_badvaddr, 32'h101);
    check("adel_en", {31'd0, data_sram_en}, 32'd0);
    idle();
    check("adel_w_regwrite", {31'd0, w_regwrite}, 32'd0);
    issue(MEMOP_SH, 32'h103, 32'h5555, 1'b0, 5'd0, 32'h1030);
    check("ades_flag", {31'd0, exc_ades}, 32'd1);
    check("ades_adel", {31'd0, exc_adel}, 32'd0);
    check("ades_wen", {28'd0, data_sram_wen}, 32'd0);
    idle();
    check("ades_cleared", {31'd0, exc_ades}, 32'd0);
`else
    issue(MEMOP_LW, 32'h101, 32'h0, 1'b1, 5'd10, 32'h102C);
    check("noexc_adel", {31'd0, exc_adel}, 32'd0);
    check("noexc_en", {31'd0, data_sram_en}, 32'd1);
    idle();
    check("noexc_result", w_result, 32'hBEEF5678);
    check("noexc_w_regwrite", {31'd0, w_regwrite}, 32'd1);
`endif

    // Store held three cycles by stall writes exactly once
    writes = 0;
    issue(MEMOP_SW, 32'h300, 32'hCAFEF00D, 1'b0, 5'd0, 32'h2000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (data_sram_wen != 4'h0) writes++;
      check("stall_en", {31'd0, data_sram_en}, 32'd0);
      step();
      check("stall_w_valid", {31'd0, w_valid}, 32'd0);
    end
    stall = 1'b0;
    set_idle();
    #1;
    if (data_sram_wen != 4'h0) writes++;
    check("stall_release_wen", {28'd0, data_sram_wen}, 32'hF);
    step();
    check("stall_w_valid_after", {31'd0, w_valid}, 32'd1);
    check("stall_w_pc", w_pc, 32'h2000);
    check("stall_write_count", writes, 32'd1);
    issue(MEMOP_LW, 32'h300, 32'h0, 1'b1, 5'd11, 32'h2004);
    idle();
    check("stall_readback", w_result, 32'hCAFEF00D);

    // Flush with a store in MEM suppresses the write and the incoming entry
    issue(MEMOP_SW, 32'h380, 32'h11111111, 1'b0, 5'd0, 32'h2008);
    e_valid = 1'b1; e_memop = MEMOP_NONE; e_aluout = 32'h77; e_regwrite = 1'b1;
    e_writereg = 5'd3; e_pc = 32'h200C;
    flush = 1'b1;
    #1;
    check("flush_en",  {31'd0, data_sram_en}, 32'd0);
    check("flush_wen", {28'd0, data_sram_wen}, 32'd0);
    step();
    check("flush_w_valid", {31'd0, w_valid}, 32'd0);
    check("flush_m_regwrite", {31'd0, m_regwrite}, 32'd0);
    flush = 1'b0;
    issue(MEMOP_LW, 32'h380, 32'h0, 1'b1, 5'd4, 32'h2010);
    idle();
    check("flush_readback", w_result, 32'h0);

    // Reset mid-stream
    issue(MEMOP_LW, 32'h100, 32'h0, 1'b1, 5'd5, 32'h3000);
    issue(MEMOP_SW, 32'h104, 32'h99999999, 1'b0, 5'd0, 32'h3004);
    resetn = 1'b0;
    step();
    check("mrst_en", {31'd0, data_sram_en}, 32'd0);
    check("mrst_wen", {28'd0, data_sram_wen}, 32'd0);
    check("mrst_addr", data_sram_addr, 32'd0);
    check("mrst_w_valid", {31'd0, w_valid}, 32'd0);
    check("mrst_w_regwrite", {31'd0, w_regwrite}, 32'd0);
    check("mrst_w_result", w_result, 32'd0);
    check("mrst_w_pc", w_pc, 32'd0);
    check("mrst_m_regwrite", {31'd0, m_regwrite}, 32'd0);
    check("mrst_m_writereg", {27'd0, m_writereg}, 32'd0);
    resetn = 1'b1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
